cmt_prog_ctrl: RTL and testbench

CMT_PROG_CTRL -- requirements
Module: cmt_prog_ctrl

---
 rtl/cmt_prog_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cmt_prog_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cmt_prog_ctrl.sv
// DCM_CLKGEN serial programming sequencer with PLL reset pulse generation.
// Optional request range check enabled by defining CMT_PROG_CTRL_RANGE_CHECK_EN.
module cmt_prog_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int DONE_TIMEOUT   = 65535
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       req_valid,
  input  logic [7:0] req_m,
  input  logic [7:0] req_d,
  output logic       req_ready,
  output logic       progen,
  output logic       progdata,
  input  logic       progdone_inv,
  output logic       pll_reset,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_range
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_D, S_GAP1, S_LOAD_M, S_GAP2, S_GO, S_WAIT_DONE, S_PLL_RST
  } state_t;

  localparam logic [15:0] TO_LOAD   = 16'(DONE_TIMEOUT - 1);
  localparam logic [15:0] PRST_LOAD = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] MASK_CYC  = 16'd4;

  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [7:0]  m_q, d_q;
  logic [1:0]  sync_q;
  logic        progen_q, progdata_q, pll_reset_q, done_q, err_to_q;
  logic        progen_n, progdata_n, pll_reset_n;
  logic        accept, range_bad, to_set, done_set, rng_set;
  logic [15:0] elapsed;
  logic        sync_done_inv;

  assign sync_done_inv = sync_q[1];
  assign accept        = req_valid & (state_q == S_IDLE);
  assign elapsed       = TO_LOAD - cnt_q;

`ifdef CMT_PROG_CTRL_RANGE_CHECK_EN
  logic [15:0] m_full, d_full;
  logic        err_rng_q;
  assign m_full    = {8'd0, req_m} + 16'd1;
  assign d_full    = {8'd0, req_d} + 16'd1;
  // Keeps the DCM VCO ratio M/D within [21/48, 56/48].
  assign range_bad = (m_full < 16'd2) ||
                     (16'd48 * m_full < 16'd21 * d_full) ||
                     (16'd48 * m_full > 16'd56 * d_full);
  assign err_range = err_rng_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) err_rng_q <= 1'b0;
    else          err_rng_q <= rng_set;
  end
`else
  assign range_bad = 1'b0;
  assign err_range = 1'b0;
`endif

  always_comb begin
    state_n  = state_q;
    cnt_n    = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
    to_set   = 1'b0;
    done_set = 1'b0;
    rng_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_n = 16'd0;
        if (accept) begin
          if (range_bad) rng_set = 1'b1;
          else begin
            state_n = S_LOAD_D;
            cnt_n   = 16'd9;
          end
        end
      end
      S_LOAD_D: if (cnt_q == 16'd0) begin state_n = S_GAP1;   cnt_n = 16'd0; end
      S_GAP1:   if (cnt_q == 16'd0) begin state_n = S_LOAD_M; cnt_n = 16'd9; end
      S_LOAD_M: if (cnt_q == 16'd0) begin state_n = S_GAP2;   cnt_n = 16'd1; end
      S_GAP2:   if (cnt_q == 16'd0) begin state_n = S_GO;     cnt_n = 16'd0; end
      S_GO: begin
        state_n = S_WAIT_DONE;
        cnt_n   = TO_LOAD;
      end
      S_WAIT_DONE: begin
        // Done wins over a timeout landing in the same cycle.
        if (!sync_done_inv && elapsed >= MASK_CYC) begin
          state_n = S_PLL_RST;
          cnt_n   = PRST_LOAD;
        end else if (cnt_q == 16'd0) begin
          state_n = S_PLL_RST;
          cnt_n   = PRST_LOAD;
          to_set  = 1'b1;
        end
      end
      S_PLL_RST: if (cnt_q == 16'd0) begin
        state_n  = S_IDLE;
        cnt_n    = 16'd0;
        done_set = ~err_to_q;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 16'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    progen_n    = 1'b0;
    progdata_n  = 1'b0;
    pll_reset_n = (state_n == S_PLL_RST);
    case (state_n)
      S_LOAD_D: begin
        progen_n   = 1'b1;
        progdata_n = cnt_n[3] ? 1'b1 : d_q[~cnt_n[2:0]];
      end
      S_LOAD_M: begin
        progen_n   = 1'b1;
        progdata_n = cnt_n[3] ? cnt_n[0] : m_q[~cnt_n[2:0]];
      end
      S_GO:    progen_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      m_q         <= 8'd0;
      d_q         <= 8'd0;
      sync_q      <= 2'b11;
      progen_q    <= 1'b0;
      progdata_q  <= 1'b0;
      pll_reset_q <= 1'b0;
      done_q      <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      sync_q      <= {sync_q[0], progdone_inv};
      progen_q    <= progen_n;
      progdata_q  <= progdata_n;
      pll_reset_q <= pll_reset_n;
      done_q      <= done_set;
      if (accept) begin
        m_q      <= req_m;
        d_q      <= req_d;
        err_to_q <= 1'b0;
      end else if (to_set) begin
        err_to_q <= 1'b1;
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign progen      = progen_q;
  assign progdata    = progdata_q;
  assign pll_reset   = pll_reset_q;
  assign done        = done_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_cmt_prog_ctrl.sv
// Self-checking bench for cmt_prog_ctrl: per-cycle waveform prediction from the
// programming protocol rules, directed corner cases plus randomized requests.
module tb_cmt_prog_ctrl;

  localparam int P = 16;
  localparam int T = 100;
`ifdef CMT_PROG_CTRL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       req_valid;
  logic [7:0] req_m, req_d;
  logic       req_ready, progen, progdata, progdone_inv;
  logic       pll_reset, busy, done, err_timeout, err_range;

  int n_cmp = 0;
  int n_bad = 0;
  bit prev_err = 1'b0;

  always #5 CLK = ~CLK;

  cmt_prog_ctrl #(.PLL_RST_CYCLES(P), .DONE_TIMEOUT(T)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_m(req_m),
    .req_d(req_d), .req_ready(req_ready), .progen(progen), .progdata(progdata),
    .progdone_inv(progdone_inv), .pll_reset(pll_reset), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_range(err_range)
  );

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
    end
  endtask

  task automatic chk_all(input int c, input logic e_pe, e_pd, e_pll, e_busy,
                         e_done, e_to, e_rng);
    chk("progen", c, progen, e_pe);
    chk("progdata", c, progdata, e_pd);
    chk("pll_reset", c, pll_reset, e_pll);
    chk("busy", c, busy, e_busy);
    chk("req_ready", c, req_ready, ~e_busy);
    chk("done", c, done, e_done);
    chk("err_timeout", c, err_timeout, e_to);
    chk("err_range", c, err_range, e_rng);
  endtask

  function automatic bit range_ok(input logic [7:0] m, input logic [7:0] d);
    int mm, dd;
    mm = int'(m) + 1;
    dd = int'(d) + 1;
    return (mm >= 2) && (48 * mm >= 21 * dd) && (48 * mm <= 56 * dd);
  endfunction

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk_all(-1, 0, 0, 0, 0, 0, prev_err, 0);
      @(negedge CLK);
    end
  endtask

  // One request accepted in cycle 0; r = cycle the DCM raises progdone_inv,
  // n = cycle it drops it again (0 = never), rst_at = cycle to pull reset (0 = none).
  task automatic run_txn(input logic [7:0] m, input logic [7:0] d, input int r,
                         input int n, input bit busy_req, input int rst_at);
    bit rej, to;
    int s, endc;
    logic pe[1:24];
    logic pd[1:24];
    logic e_pe, e_pd;
    rej = RC && !range_ok(m, d);
    for (int i = 1; i <= 24; i++) begin pe[i] = 0; pd[i] = 0; end
    for (int i = 1; i <= 10; i++) pe[i] = 1;
    for (int i = 12; i <= 21; i++) pe[i] = 1;
    pe[24] = 1;
    pd[1] = 1; pd[2] = 1; pd[12] = 1; pd[13] = 0;
    for (int k = 0; k < 8; k++) begin
      pd[3 + k]  = d[k];
      pd[14 + k] = m[k];
    end
    // Sync latency 2, decision 1 cycle later; first 4 wait cycles masked.
    if (n > 0 && n + 3 <= 25 + T) begin
      s  = (n + 3 > 30) ? n + 3 : 30;
      to = 0;
    end else begin
      s  = 25 + T;
      to = 1;
    end
    endc = rej ? 2 : s + P;
    for (int c = 0; c <= endc; c++) begin
      if (rej) begin
        chk_all(c, 0, 0, 0, 0, 0, (c == 0) ? prev_err : 1'b0, c == 1);
      end else begin
        e_pe = (c >= 1 && c <= 24) ? pe[c] : 1'b0;
        e_pd = (c >= 1 && c <= 24) ? pd[c] : 1'b0;
        chk_all(c, e_pe, e_pd, c >= s && c < s + P, c >= 1 && c < s + P,
                c == s + P && !to, (c == 0) ? prev_err : (to && c >= s), 0);
      end
      if (rst_at > 0 && c == rst_at) begin
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_progen", c, progen, 1'b0);
        chk("rst_busy", c, busy, 1'b0);
        chk("rst_ready", c, req_ready, 1'b1);
        chk("rst_pll", c, pll_reset, 1'b0);
        @(negedge CLK);
        RESET_N      = 1'b1;
        req_valid    = 1'b0;
        progdone_inv = 1'b0;
        prev_err     = 1'b0;
        return;
      end
      req_valid = (c == 0) || (busy_req && c >= 26 && c <= 40);
      if (c > 0) begin
        req_m = 8'($urandom);
        req_d = 8'($urandom);
      end else begin
        req_m = m;
        req_d = d;
      end
      if (c >= r && (n == 0 || c < n)) progdone_inv = 1'b1;
      else if (n > 0 && c >= n)        progdone_inv = 1'b0;
      @(negedge CLK);
    end
    req_valid    = 1'b0;
    progdone_inv = 1'b0;
    prev_err     = rej ? 1'b0 : to;
  endtask

  initial begin
    RESET_N      = 1'b0;
    req_valid    = 1'b0;
    req_m        = 8'd0;
    req_d        = 8'd0;
    progdone_inv = 1'b0;
    #12;
    chk_all(-2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    idle(2);

    run_txn(8'd19, 8'd26, 10, 44, 0, 0);   // reference sequence, done 20 after GO
    idle(3);
    run_txn(8'd19, 8'd26, 5, 0, 0, 0);     // progdone never returns: timeout
    idle(2);
    run_txn(8'd19, 8'd26, 27, 60, 1, 0);   // requests during WAIT_DONE ignored
    idle(2);
    run_txn(8'd19, 8'd26, 8, 50, 0, 16);   // reset during LOAD_M bit 4
    idle(3);
    run_txn(8'd19, 8'd26, 3, 122, 0, 0);   // done seen in the last wait cycle
    idle(1);
    run_txn(8'd19, 8'd26, 3, 123, 0, 0);   // one cycle too late: timeout
    idle(2);
    run_txn(8'd1, 8'd9, 4, 40, 0, 0);      // M=2, D=10
    idle(2);
    run_txn(8'd37, 8'd41, 4, 40, 0, 0);    // M=38, D=42
    idle(2);
    for (int i = 0; i < 8; i++) begin
      run_txn(8'($urandom), 8'($urandom), int'($urandom_range(1, 27)),
              int'($urandom_range(28, 130)), 1'($urandom), 0);
      idle(int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
